axi4_reg_slice: RTL



---
 rtl/axi4_reg_slice_pkg.sv | 49 ++++
 rtl/axi4_reg_slice_if.sv | 83 ++++++++
 rtl/axi4_reg_slice_pipe_stage.sv | 100 ++++++++++
 rtl/axi4_reg_slice.sv | 87 ++++++++
 4 files changed

// File: rtl/axi4_reg_slice_pkg.sv
// Shared types, slice-mode constants and per-channel payload width helpers
// for the AXI4 register slice.
package axi4_pkg;

  localparam int AXI_SLICE_BYPASS = 0;
  localparam int AXI_SLICE_FWD    = 1;
  localparam int AXI_SLICE_FULL   = 2;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } axi_burst_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } pipe_state_e;

  // id + addr + len(8) + size(3) + burst(2) + lock(1) + cache(4) + prot(3) + qos(4) + region(4) + user
  function automatic int axi_ax_width(int addr_w, int id_w, int user_w);
    return id_w + addr_w + 8 + 3 + 2 + 1 + 4 + 3 + 4 + 4 + user_w;
  endfunction

  function automatic int axi_w_width(int data_w, int id_w, int user_w);
    return id_w + data_w + data_w / 8 + 1 + user_w;
  endfunction

  function automatic int axi_b_width(int id_w, int user_w);
    return id_w + 2 + user_w;
  endfunction

  function automatic int axi_r_width(int data_w, int id_w, int user_w);
    return id_w + data_w + 2 + 1 + user_w;
  endfunction

  function automatic bit axi_mode_ok(int mode);
    return (mode >= AXI_SLICE_BYPASS) && (mode <= AXI_SLICE_FULL);
  endfunction

endpackage

// File: rtl/axi4_reg_slice_if.sv
// AXI4 five-channel bus bundle; master drives AW/W/AR and the B/R readies.
interface ifc_axi4 #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int USER_WIDTH = 1
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awlock;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic [3:0]              awqos;
  logic [3:0]              awregion;
  logic [USER_WIDTH-1:0]   awuser;
  logic                    awvalid;
  logic                    awready;

  logic [ID_WIDTH-1:0]     wid;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic [USER_WIDTH-1:0]   wuser;
  logic                    wvalid;
  logic                    wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic [USER_WIDTH-1:0]   buser;
  logic                    bvalid;
  logic                    bready;

  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arlock;
  logic [3:0]              arcache;
  logic [2:0]              arprot;
  logic [3:0]              arqos;
  logic [3:0]              arregion;
  logic [USER_WIDTH-1:0]   aruser;
  logic                    arvalid;
  logic                    arready;

  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic [USER_WIDTH-1:0]   ruser;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awuser, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wuser, wvalid,
    input  wready,
    input  bid, bresp, buser, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, aruser, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, ruser, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awuser, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wuser, wvalid,
    output wready,
    output bid, bresp, buser, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, aruser, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, ruser, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi4_reg_slice_pipe_stage.sv
// Generic valid/ready pipeline stage: bypass, forward-registered, or full skid buffer.
// Payload registers are deliberately left without reset; only control state resets.
module axi_pipe_stage
  import axi4_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int MODE  = AXI_SLICE_FULL
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  if (MODE == AXI_SLICE_BYPASS) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign out_valid = in_valid;
    assign out_data  = in_data;
    assign in_ready  = out_ready;
  end else if (MODE == AXI_SLICE_FWD) begin : g_fwd
    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    assign in_ready  = out_ready | ~valid_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) valid_q <= 1'b0;
      else if (in_ready) valid_q <= in_valid;
    end

    always_ff @(posedge clk) begin
      if (in_valid && in_ready) data_q <= in_data;
    end
  end else begin : g_full
    pipe_state_e      state_q, state_d;
    logic             ready_q;
    logic [WIDTH-1:0] main_q, skid_q;
    logic             load_main_in, load_main_skid, load_skid;
    logic             in_hs, out_hs;

    assign in_ready  = ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;
    assign in_hs     = in_valid & ready_q;
    assign out_hs    = out_valid & out_ready;

    // ready is a flop so the upstream never sees a combinational path from out_ready
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= ST_EMPTY;
        ready_q <= 1'b0;
      end else begin
        state_q <= state_d;
        ready_q <= (state_d != ST_TWO);
      end
    end

    always_comb begin
      state_d        = state_q;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      case (state_q)
        ST_EMPTY: if (in_hs) begin
          state_d      = ST_ONE;
          load_main_in = 1'b1;
        end
        ST_ONE: begin
          if (in_hs && out_hs) begin
            load_main_in = 1'b1;
          end else if (in_hs) begin
            state_d   = ST_TWO;
            load_skid = 1'b1;
          end else if (out_hs) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: if (out_hs) begin
          state_d        = ST_ONE;
          load_main_skid = 1'b1;
        end
        default: state_d = ST_EMPTY;
      endcase
    end

    always_ff @(posedge clk) begin
      if (load_main_in) main_q <= in_data;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid) skid_q <= in_data;
    end
  end

endmodule

// File: rtl/axi4_reg_slice.sv
// AXI4 register slice: packs each channel into a flat payload and runs it
// through an independently configured pipe stage.
module axi4_reg_slice
  import axi4_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int USER_WIDTH = 1,
  parameter int MODE_AW    = 2,
  parameter int MODE_W     = 2,
  parameter int MODE_B     = 1,
  parameter int MODE_AR    = 2,
  parameter int MODE_R     = 2
) (
  input logic     clk,
  input logic     rst_n,
  ifc_axi4.slave  s_axi,
  ifc_axi4.master m_axi
);

  localparam int AX_W = axi_ax_width(ADDR_WIDTH, ID_WIDTH, USER_WIDTH);
  localparam int W_W  = axi_w_width(DATA_WIDTH, ID_WIDTH, USER_WIDTH);
  localparam int B_W  = axi_b_width(ID_WIDTH, USER_WIDTH);
  localparam int R_W  = axi_r_width(DATA_WIDTH, ID_WIDTH, USER_WIDTH);

  if (!axi_mode_ok(MODE_AW) || !axi_mode_ok(MODE_W) || !axi_mode_ok(MODE_B) ||
      !axi_mode_ok(MODE_AR) || !axi_mode_ok(MODE_R) || ID_WIDTH < 1 || USER_WIDTH < 1) begin : g_param_check
    $error("axi4_reg_slice: illegal MODE_* or ID/USER width parameter");
  end

  logic [AX_W-1:0] aw_in, aw_out, ar_in, ar_out;
  logic [W_W-1:0]  w_in, w_out;
  logic [B_W-1:0]  b_in, b_out;
  logic [R_W-1:0]  r_in, r_out;

  assign aw_in = {s_axi.awid, s_axi.awaddr, s_axi.awlen, s_axi.awsize, s_axi.awburst, s_axi.awlock,
                  s_axi.awcache, s_axi.awprot, s_axi.awqos, s_axi.awregion, s_axi.awuser};
  assign {m_axi.awid, m_axi.awaddr, m_axi.awlen, m_axi.awsize, m_axi.awburst, m_axi.awlock,
          m_axi.awcache, m_axi.awprot, m_axi.awqos, m_axi.awregion, m_axi.awuser} = aw_out;

  assign w_in = {s_axi.wid, s_axi.wdata, s_axi.wstrb, s_axi.wlast, s_axi.wuser};
  assign {m_axi.wid, m_axi.wdata, m_axi.wstrb, m_axi.wlast, m_axi.wuser} = w_out;

  assign ar_in = {s_axi.arid, s_axi.araddr, s_axi.arlen, s_axi.arsize, s_axi.arburst, s_axi.arlock,
                  s_axi.arcache, s_axi.arprot, s_axi.arqos, s_axi.arregion, s_axi.aruser};
  assign {m_axi.arid, m_axi.araddr, m_axi.arlen, m_axi.arsize, m_axi.arburst, m_axi.arlock,
          m_axi.arcache, m_axi.arprot, m_axi.arqos, m_axi.arregion, m_axi.aruser} = ar_out;

  // B and R run downstream-to-upstream
  assign b_in = {m_axi.bid, m_axi.bresp, m_axi.buser};
  assign {s_axi.bid, s_axi.bresp, s_axi.buser} = b_out;

  assign r_in = {m_axi.rid, m_axi.rdata, m_axi.rresp, m_axi.rlast, m_axi.ruser};
  assign {s_axi.rid, s_axi.rdata, s_axi.rresp, s_axi.rlast, s_axi.ruser} = r_out;

  axi_pipe_stage #(.WIDTH(AX_W), .MODE(MODE_AW)) u_aw (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_axi.awvalid), .in_ready(s_axi.awready), .in_data(aw_in),
    .out_valid(m_axi.awvalid), .out_ready(m_axi.awready), .out_data(aw_out)
  );

  axi_pipe_stage #(.WIDTH(W_W), .MODE(MODE_W)) u_w (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_axi.wvalid), .in_ready(s_axi.wready), .in_data(w_in),
    .out_valid(m_axi.wvalid), .out_ready(m_axi.wready), .out_data(w_out)
  );

  axi_pipe_stage #(.WIDTH(B_W), .MODE(MODE_B)) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(m_axi.bvalid), .in_ready(m_axi.bready), .in_data(b_in),
    .out_valid(s_axi.bvalid), .out_ready(s_axi.bready), .out_data(b_out)
  );

  axi_pipe_stage #(.WIDTH(AX_W), .MODE(MODE_AR)) u_ar (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_axi.arvalid), .in_ready(s_axi.arready), .in_data(ar_in),
    .out_valid(m_axi.arvalid), .out_ready(m_axi.arready), .out_data(ar_out)
  );

  axi_pipe_stage #(.WIDTH(R_W), .MODE(MODE_R)) u_r (
    .clk(clk), .rst_n(rst_n),
    .in_valid(m_axi.rvalid), .in_ready(m_axi.rready), .in_data(r_in),
    .out_valid(s_axi.rvalid), .out_ready(s_axi.rready), .out_data(r_out)
  );

endmodule
